maze_pixel_plotter: RTL and testbench
=====================================

// Module: maze_pixel_plotter
// PURPOSE
//  Downstream stage of the maze position counter: consumes its per-pixel (x,y) stream and cell address.
//  Fetches each cell's code from maze RAM and maps code (plus player overlay) to a colour.
//  Drives the VGA adapter plot interface with RAM latency compensated.
//  Sequences one full-maze redraw per start pulse and reports completion to the game controller.
// PARAMETERS
//  RAM_LAT     2       cycles from cell_addr presented to ram_q valid (1..4)
//  COL_PATH    3'b111  colour for cell code 0 (open path)
//  COL_WALL    3'b000  colour for cell code 1 (wall)
//  COL_START   3'b010  colour for cell code 2 (start)
//  COL_EXIT    3'b001  colour for cell code 3 (exit)
//  COL_PLAYER  3'b100  colour when cell_addr == player_addr (overrides code)
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  reset        in   1   synchronous, active-high
//  start        in   1   pulse: begin one maze redraw (ignored unless IDLE)
//  scan_enable  out  1   enable to position counter; high only in SCAN
//  pix_x        in   9   pixel x from position counter
//  pix_y        in   9   pixel y from position counter
//  pix_valid    in   1   pix_x/pix_y/cell_addr are a real box pixel this cycle
//  cell_addr    in   10  maze cell address (x + y*32) for current pixel
//  scan_done    in   1   position counter finished last cell
//  player_addr  in   10  current player cell address
//  ram_addr     out  10  maze RAM read address (= cell_addr, combinational)
//  ram_q        in   2   maze RAM cell code, valid RAM_LAT cycles after ram_addr
//  vga_x        out  9   plot x
//  vga_y        out  9   plot y
//  vga_colour   out  3   plot colour
//  vga_plot     out  1   write strobe to VGA adapter
//  busy         out  1   high in any state except IDLE
//  frame_done   out  1   single-cycle pulse: redraw complete
// BEHAVIOUR
//  - Reset: state IDLE; vga_x/vga_y/vga_colour/vga_plot/busy/frame_done/scan_enable = 0; delay line valids cleared.
//  - FSM: IDLE -start-> SCAN -scan_done-> FLUSH (RAM_LAT+1 cycles) -> DONE (1 cycle) -> IDLE.
//  - Accept rule: pixel accepted on a cycle where state==SCAN && pix_valid, including the scan_done cycle.
//    - Accepted pixel enters delay line: {x, y, player_hit = (cell_addr==player_addr)}, RAM_LAT stages.
//  - At stage RAM_LAT, colour is chosen: player_hit ? COL_PLAYER : map(ram_q); result is registered into vga_*.
//  - Latency: pixel accepted at cycle t -> vga_plot=1 with that x,y,colour at t+RAM_LAT+1.
//  - One plot per accepted pixel; order preserved; no drops, no duplicates.
//  - vga_plot=0 on bubble cycles; vga_x/y/colour hold their last value.
//  - frame_done: pulse at scan_done cycle + RAM_LAT+2, strictly after the final plot.
//  - busy: high from the cycle after start through the DONE cycle.
//  - start while busy: ignored, no restart. start and scan_done together in IDLE: scan_done ignored.
//  - scan_done outside SCAN: ignored.
//  - pix_valid outside SCAN: ignored; no plot generated.
//  - Reset mid-operation:
//    - next cycle vga_plot=0, scan_enable=0, IDLE;
//    - in-flight pixels discarded; no frame_done.
//  - Widths: address compare is 10-bit exact; x/y pass through unmodified, no arithmetic on them.
// STRUCTURE
//  - Shared header maze_defs.vh: cell code constants (CELL_PATH/WALL/START/EXIT), default colours, MAZE_X_ORIGIN=80, address width 10.
//  - Sub-module maze_delay_line: parameterised shift register (WIDTH, DEPTH), synchronous clear on reset.
//    - Used once with WIDTH = 9+9+1+1 (x, y, player_hit, valid).
//  - FSM and flush counter ($clog2(RAM_LAT+2) bits) live in this module.
// TESTING
//  1. Assert reset 2 cycles mid-stream -> all outputs 0 next cycle; state IDLE; no frame_done afterwards.
//  2. start; pixel (85,3) valid, cell_addr=5, ram_q=1 at t+2 -> at t+3: vga_plot=1, x=85, y=3, colour=000.
//  3. As test 2 with player_addr=5 and ram_q=0 -> colour=100; player_addr=6 -> colour=111.
//  4. 4 pixels with pix_valid pattern 1,0,1,1 -> exactly 3 plots in order at t+3, t+5, t+6.
//  5. scan_done at cycle N with a last pixel -> last plot at N+3; frame_done high only at N+4; busy low at N+5.
//  6. start pulsed during SCAN and scan_done pulsed in IDLE -> no restart, no extra frame_done; scan_enable unchanged.

Source files
------------

// File: rtl/maze_pixel_plotter_pkg.sv
// Shared definitions for the maze pixel plotter.
//  - address / coordinate / colour widths
//  - cell code encoding and default colours
//  - plotter FSM state type and delay-line entry layout
//  - cell_colour(): cell code -> colour lookup
package maze_pixel_plotter_pkg;

  localparam int unsigned AddrWidth   = 10;
  localparam int unsigned CoordWidth  = 9;
  localparam int unsigned ColourWidth = 3;

  typedef enum logic [1:0] {
    CellPath  = 2'd0,
    CellWall  = 2'd1,
    CellStart = 2'd2,
    CellExit  = 2'd3
  } cell_code_e;

  localparam logic [ColourWidth-1:0] ColPathDefault   = 3'b111;
  localparam logic [ColourWidth-1:0] ColWallDefault   = 3'b000;
  localparam logic [ColourWidth-1:0] ColStartDefault  = 3'b010;
  localparam logic [ColourWidth-1:0] ColExitDefault   = 3'b001;
  localparam logic [ColourWidth-1:0] ColPlayerDefault = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StFlush,
    StDone
  } plot_state_e;

  // One pixel travelling alongside its RAM read.
  typedef struct packed {
    logic [CoordWidth-1:0] x;
    logic [CoordWidth-1:0] y;
    logic                  player_hit;
    logic                  valid;
  } pix_entry_t;

  function automatic logic [ColourWidth-1:0] cell_colour(
    input cell_code_e             code,
    input logic [ColourWidth-1:0] col_path,
    input logic [ColourWidth-1:0] col_wall,
    input logic [ColourWidth-1:0] col_start,
    input logic [ColourWidth-1:0] col_exit
  );
    logic [ColourWidth-1:0] col;
    unique case (code)
      CellPath:  col = col_path;
      CellWall:  col = col_wall;
      CellStart: col = col_start;
      CellExit:  col = col_exit;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/maze_delay_line.sv
// Fixed-depth shift register with synchronous clear.
//  clk    in   system clock
//  reset  in   synchronous active-high clear of every stage
//  din    in   WIDTH-bit word entering stage 1
//  dout   out  word after DEPTH cycles
module maze_delay_line #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/maze_pixel_plotter.sv
// Maze pixel plotter: turns the position counter's pixel stream into VGA plot writes.
//  clk, reset              system clock, synchronous active-high reset
//  start                   begin one full-maze redraw (only honoured when idle)
//  scan_enable             run enable to the position counter (SCAN only)
//  pix_x/pix_y/pix_valid   current pixel from the position counter
//  cell_addr, scan_done    current cell address, last-cell marker
//  player_addr             cell holding the player (drawn in COL_PLAYER)
//  ram_addr / ram_q        maze RAM read port, ram_q valid RAM_LAT cycles later
//  vga_x/vga_y/vga_colour  plot data, vga_plot write strobe
//  busy, frame_done        activity flag and end-of-redraw pulse
module maze_pixel_plotter
  import maze_pixel_plotter_pkg::*;
#(
  parameter int unsigned             RAM_LAT    = 2,
  parameter logic [ColourWidth-1:0]  COL_PATH   = ColPathDefault,
  parameter logic [ColourWidth-1:0]  COL_WALL   = ColWallDefault,
  parameter logic [ColourWidth-1:0]  COL_START  = ColStartDefault,
  parameter logic [ColourWidth-1:0]  COL_EXIT   = ColExitDefault,
  parameter logic [ColourWidth-1:0]  COL_PLAYER = ColPlayerDefault
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   scan_enable,
  input  logic [CoordWidth-1:0]  pix_x,
  input  logic [CoordWidth-1:0]  pix_y,
  input  logic                   pix_valid,
  input  logic [AddrWidth-1:0]   cell_addr,
  input  logic                   scan_done,
  input  logic [AddrWidth-1:0]   player_addr,
  output logic [AddrWidth-1:0]   ram_addr,
  input  logic [1:0]             ram_q,
  output logic [CoordWidth-1:0]  vga_x,
  output logic [CoordWidth-1:0]  vga_y,
  output logic [ColourWidth-1:0] vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned CntW = $clog2(RAM_LAT + 2);
  // FLUSH runs for RAM_LAT+1 cycles: long enough for the last pixel to reach vga_*.
  localparam logic [CntW-1:0] FlushLast = CntW'(RAM_LAT);

  plot_state_e     state_q, state_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;

  logic       accept;
  pix_entry_t entry_in;
  pix_entry_t entry_out;

  logic [CoordWidth-1:0]  vga_x_q;
  logic [CoordWidth-1:0]  vga_y_q;
  logic [ColourWidth-1:0] vga_colour_q;
  logic                   vga_plot_q;
  logic [ColourWidth-1:0] colour_sel;

  // The RAM sees the cell address directly; the delay line keeps the pixel in step with ram_q.
  assign ram_addr = cell_addr;
  assign accept   = (state_q == StScan) && pix_valid;

  always_comb begin
    entry_in            = '0;
    entry_in.x          = pix_x;
    entry_in.y          = pix_y;
    entry_in.player_hit = (cell_addr == player_addr);
    entry_in.valid      = accept;
  end

  maze_delay_line #(
    .WIDTH ($bits(pix_entry_t)),
    .DEPTH (RAM_LAT)
  ) u_delay_line (
    .clk   (clk),
    .reset (reset),
    .din   (entry_in),
    .dout  (entry_out)
  );

  always_comb begin
    colour_sel = cell_colour(cell_code_e'(ram_q), COL_PATH, COL_WALL, COL_START, COL_EXIT);
    if (entry_out.player_hit) begin
      colour_sel = COL_PLAYER;
    end
  end

  // Plot register: data only moves on a real pixel so bubbles leave x/y/colour unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      vga_plot_q <= entry_out.valid;
      if (entry_out.valid) begin
        vga_x_q      <= entry_out.x;
        vga_y_q      <= entry_out.y;
        vga_colour_q <= colour_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
        end
      end
      StScan: begin
        if (scan_done) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
        end
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) begin
          state_d = StDone;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  assign scan_enable = (state_q == StScan);
  assign busy        = (state_q != StIdle);
  assign frame_done  = (state_q == StDone);

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_maze_pixel_plotter.sv
// Scoreboard bench for maze_pixel_plotter: a driver issues random and directed pixel
// streams and pushes expected plots; a negedge monitor pops and compares them.
module tb_maze_pixel_plotter;

  localparam int RAM_LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       scan_enable;
  logic [8:0] pix_x, pix_y;
  logic       pix_valid;
  logic [9:0] cell_addr;
  logic       scan_done;
  logic [9:0] player_addr;
  logic [9:0] ram_addr;
  logic [1:0] ram_q;
  logic [8:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       frame_done;

  maze_pixel_plotter #(.RAM_LAT(RAM_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .scan_enable (scan_enable),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .cell_addr   (cell_addr),
    .scan_done   (scan_done),
    .player_addr (player_addr),
    .ram_addr    (ram_addr),
    .ram_q       (ram_q),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Maze RAM with RAM_LAT read latency.
  bit [1:0] mem [1024];
  bit [1:0] ram_pipe [RAM_LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_q = ram_pipe[RAM_LAT-1];

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] c;
    int         due;
  } exp_t;
  exp_t exq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 scanning, 2 draining until the frame_done cycle.
  int m_state    = 0;
  bit fd_pending = 1'b0;
  int exp_fd     = 0;
  bit exp_busy   = 1'b0;
  bit exp_scan   = 1'b0;
  bit mon_en     = 1'b0;

  function automatic logic [2:0] ref_colour(input bit [1:0] code, input bit hit);
    if (hit) return 3'b100;
    case (code)
      2'd0:    return 3'b111;
      2'd1:    return 3'b000;
      2'd2:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit st, input bit pv, input logic [8:0] x, input logic [8:0] y,
                      input logic [9:0] ca, input bit sd, input bit rst);
    int nxt;
    if (m_state == 2 && cyc > exp_fd) begin
      m_state    = 0;
      fd_pending = 1'b0;
    end
    exp_busy    = (m_state != 0);
    exp_scan    = (m_state == 1);
    start       = st;
    pix_valid   = pv;
    pix_x       = x;
    pix_y       = y;
    cell_addr   = ca;
    scan_done   = sd;
    reset       = rst;
    nxt         = m_state;
    if (rst) begin
      nxt        = 0;
      fd_pending = 1'b0;
      while (exq.size() > 0 && exq[exq.size()-1].due > cyc) void'(exq.pop_back());
    end else begin
      if (m_state == 1 && pv) begin
        exp_t e;
        e.x   = x;
        e.y   = y;
        e.c   = ref_colour(mem[ca], ca == player_addr);
        e.due = cyc + RAM_LAT + 1;
        exq.push_back(e);
      end
      if (m_state == 0 && st) nxt = 1;
      if (m_state == 1 && sd) begin
        nxt        = 2;
        fd_pending = 1'b1;
        exp_fd     = cyc + RAM_LAT + 2;
      end
    end
    @(posedge clk);
    #1;
    m_state = nxt;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 9'd0, 9'd0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic rand_step(input bit allow_sd);
    logic [9:0] ca;
    ca = ($urandom_range(0, 3) == 0) ? player_addr : 10'($urandom_range(0, 1023));
    step($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, 9'($urandom), 9'($urandom), ca,
         allow_sd && ($urandom_range(0, 5) == 0), 1'b0);
  endtask

  // Monitor: control outputs every cycle, plot stream against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("scan_enable", int'(scan_enable), int'(exp_scan));
      chk("frame_done", int'(frame_done), int'(fd_pending && cyc == exp_fd));
      if (vga_plot) begin
        if (exq.size() == 0) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          exp_t e;
          e = exq.pop_front();
          chk("plot_cycle", cyc, e.due);
          chk("vga_x", int'(vga_x), int'(e.x));
          chk("vga_y", int'(vga_y), int'(e.y));
          chk("vga_colour", int'(vga_colour), int'(e.c));
        end
      end else if (exq.size() > 0 && exq[0].due <= cyc) begin
        exp_t e;
        e = exq.pop_front();
        chk("missing_plot_due", cyc, e.due + 1000000);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'($urandom);
    mem[5] = 2'd1;
    mem[6] = 2'd0;
    player_addr = 10'd900;
    start = 0; pix_valid = 0; pix_x = 0; pix_y = 0; cell_addr = 0; scan_done = 0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset values.
    chk("rst_vga_plot", int'(vga_plot), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_colour", int'(vga_colour), 0);
    idle_step();

    // Directed: wall pixel, player overlay, path pixel, valid pattern 1,0,1,1.
    step(1'b1, 1'b0, 9'd0, 9'd0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 9'd85, 9'd3, 10'd5, 1'b0, 1'b0);
    player_addr = 10'd6;
    step(1'b0, 1'b1, 9'd86, 9'd3, 10'd6, 1'b0, 1'b0);
    player_addr = 10'd5;
    step(1'b0, 1'b1, 9'd87, 9'd3, 10'd6, 1'b0, 1'b0);
    step(1'b0, 1'b1, 9'd88, 9'd4, 10'd6, 1'b0, 1'b0);
    step(1'b0, 1'b0, 9'd89, 9'd4, 10'd6, 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'd90, 9'd4, 10'd5, 1'b0, 1'b0);  // start during SCAN is ignored
    step(1'b0, 1'b1, 9'd91, 9'd4, 10'd6, 1'b1, 1'b0);  // last pixel on scan_done cycle
    for (int i = 0; i < 8; i++) idle_step();
    // scan_done alone in IDLE, then start together with scan_done in IDLE.
    step(1'b0, 1'b1, 9'd1, 9'd1, 10'd1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 9'd2, 9'd2, 10'd2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) rand_step(1'b0);
    step(1'b0, 1'b1, 9'd3, 9'd3, 10'd3, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) idle_step();

    // Reset mid-stream with pixels in flight.
    step(1'b1, 1'b0, 9'd0, 9'd0, 10'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) rand_step(1'b0);
    step(1'b0, 1'b1, 9'd10, 9'd10, 10'd10, 1'b0, 1'b1);
    chk("midrst_vga_plot", int'(vga_plot), 0);
    chk("midrst_vga_x", int'(vga_x), 0);
    chk("midrst_vga_y", int'(vga_y), 0);
    chk("midrst_vga_colour", int'(vga_colour), 0);
    chk("midrst_scan_enable", int'(scan_enable), 0);
    chk("midrst_busy", int'(busy), 0);
    step(1'b0, 1'b1, 9'd11, 9'd11, 10'd11, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) idle_step();

    // Random frames.
    for (int f = 0; f < 30; f++) begin
      player_addr = 10'($urandom);
      step(1'b1, $urandom_range(0, 1) == 1, 9'($urandom), 9'($urandom), 10'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 40 && m_state == 1; i++) rand_step(1'b1);
      if (m_state == 1) step(1'b0, 1'b1, 9'($urandom), 9'($urandom), player_addr, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) rand_step(1'b1);
    end
    for (int i = 0; i < 10; i++) idle_step();

    chk("scoreboard_empty", exq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
